// File: rtl/neuron_integrator_if.sv
`default_nettype none
// ============================================================================
// Module   : neuron_integrator_if
// Brief    : Synaptic-event input, spike output and status bundle for the
//            neuron integrator.
// Revision : 1.0 - initial release
// ============================================================================
interface neuron_integrator_if #(
    parameter int ID_WIDTH     = 4,
    parameter int WEIGHT_WIDTH = 4
);
    logic [2:0]              MODE;
    logic                    Syn_Valid_In;
    logic                    Syn_Ready_Out;
    logic [ID_WIDTH-1:0]     DstID_In;
    logic [WEIGHT_WIDTH-1:0] Weight_In;
    logic                    Step_In;
    logic                    Spike_Valid_Out;
    logic [ID_WIDTH-1:0]     Spike_ID_Out;
    logic                    Spike_Ready_In;
    logic                    Busy_Out;
    logic                    Scan_Done_Out;
    logic                    Step_Miss_Out;

    modport master (
        output MODE, Syn_Valid_In, DstID_In, Weight_In, Step_In, Spike_Ready_In,
        input  Syn_Ready_Out, Spike_Valid_Out, Spike_ID_Out, Busy_Out,
               Scan_Done_Out, Step_Miss_Out
    );

    modport slave (
        input  MODE, Syn_Valid_In, DstID_In, Weight_In, Step_In, Spike_Ready_In,
        output Syn_Ready_Out, Spike_Valid_Out, Spike_ID_Out, Busy_Out,
               Scan_Done_Out, Step_Miss_Out
    );
endinterface
`default_nettype wire

// File: rtl/neuron_integrator.sv
`default_nettype none
// ============================================================================
// Module   : neuron_integrator
// Brief    : Integrates routed synaptic events into membrane potentials and
//            scans for threshold/fire and leak on each timestep.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_integrator #(
    parameter int                            ID_WIDTH     = 4,
    parameter int                            WEIGHT_WIDTH = 4,
    parameter int                            POT_WIDTH    = 8,
    parameter logic signed [POT_WIDTH-1:0]   THRESHOLD    = 8'sd32,
    parameter logic        [POT_WIDTH-1:0]   LEAK         = 8'd1,
    parameter int                            FIFO_DEPTH   = 4
) (
    input wire logic           clk,
    input wire logic           rst_n,
    neuron_integrator_if.slave bus
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam logic [2:0]              c_mode_f    = 3'b011;
    localparam logic [2:0]              c_mode_rst  = 3'b101;
    localparam int                      c_neurons   = 2 ** ID_WIDTH;
    localparam int                      c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam logic [ID_WIDTH-1:0]     c_last_idx  = '1;
    localparam logic [c_ptr_w:0]        c_fifo_full = FIFO_DEPTH[c_ptr_w:0];
    localparam logic signed [POT_WIDTH:0] c_leak_w  = $signed({1'b0, LEAK});

    state_t                       r_state;
    logic [ID_WIDTH-1:0]          r_idx;
    logic signed [POT_WIDTH-1:0]  r_pot [c_neurons];
    logic [ID_WIDTH-1:0]          r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]           r_wr_ptr;
    logic [c_ptr_w-1:0]           r_rd_ptr;
    logic [c_ptr_w:0]             r_count;
    logic                         r_step_miss;

    logic                         w_mode_rst;
    logic                         w_syn_ready;
    logic                         w_syn_fire;
    logic                         w_empty;
    logic                         w_full;
    logic                         w_pop;
    logic                         w_fires;
    logic                         w_stall;
    logic                         w_advance;
    logic                         w_push;
    logic                         w_scan_done;
    logic signed [POT_WIDTH-1:0]  w_cur;
    logic signed [POT_WIDTH:0]    w_sum;
    logic signed [POT_WIDTH-1:0]  w_sat;
    logic signed [POT_WIDTH:0]    w_dec;
    logic signed [POT_WIDTH:0]    w_inc;
    logic signed [POT_WIDTH-1:0]  w_next_pot;

    always_comb begin
        w_mode_rst  = (bus.MODE == c_mode_rst);
        w_syn_ready = rst_n && (r_state == S_IDLE) && (bus.MODE == c_mode_f);
        w_syn_fire  = bus.Syn_Valid_In && w_syn_ready;
        w_empty     = (r_count == '0);
        w_full      = (r_count == c_fifo_full);
        w_pop       = !w_empty && bus.Spike_Ready_In;
        w_cur       = r_pot[r_idx];
        w_fires     = (w_cur >= THRESHOLD);
        // A full FIFO only blocks a firing neuron when nothing leaves this cycle.
        w_stall     = (r_state == S_SCAN) && w_fires && w_full && !w_pop;
        w_advance   = (r_state == S_SCAN) && !w_stall && rst_n && !w_mode_rst;
        w_push      = w_advance && w_fires;
        w_scan_done = w_advance && (r_idx == c_last_idx);

        // Operands fit in POT_WIDTH+1 bits, so overflow shows as a top-two-bit mismatch.
        w_sum = (POT_WIDTH+1)'(r_pot[bus.DstID_In]) + (POT_WIDTH+1)'($signed(bus.Weight_In));
        if (w_sum[POT_WIDTH] != w_sum[POT_WIDTH-1]) begin
            w_sat = w_sum[POT_WIDTH] ? {1'b1, {(POT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(POT_WIDTH-1){1'b1}}};
        end else begin
            w_sat = w_sum[POT_WIDTH-1:0];
        end

        w_dec = (POT_WIDTH+1)'(w_cur) - c_leak_w;
        w_inc = (POT_WIDTH+1)'(w_cur) + c_leak_w;
        if (w_fires) begin
            w_next_pot = '0;
        end else if (!w_cur[POT_WIDTH-1] && (|w_cur)) begin
            w_next_pot = w_dec[POT_WIDTH] ? '0 : w_dec[POT_WIDTH-1:0];
        end else if (w_cur[POT_WIDTH-1]) begin
            w_next_pot = (!w_inc[POT_WIDTH] && (|w_inc)) ? '0 : w_inc[POT_WIDTH-1:0];
        end else begin
            w_next_pot = w_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_mode_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_step_miss <= 1'b0;
            for (int i = 0; i < c_neurons; i++) begin
                r_pot[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);

            case (r_state)
                S_IDLE: begin
                    if (w_syn_fire) begin
                        r_pot[bus.DstID_In] <= w_sat;
                    end
                    if (bus.Step_In) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                    end
                end
                S_SCAN: begin
                    if (bus.Step_In) begin
                        r_step_miss <= 1'b1;
                    end
                    if (w_advance) begin
                        r_pot[r_idx] <= w_next_pot;
                        r_idx        <= r_idx + ID_WIDTH'(1);
                        if (r_idx == c_last_idx) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_idx;
        end
    end

    assign bus.Syn_Ready_Out   = w_syn_ready;
    assign bus.Spike_Valid_Out = !w_empty;
    assign bus.Spike_ID_Out    = w_empty ? '0 : r_fifo[r_rd_ptr];
    assign bus.Busy_Out        = (r_state == S_SCAN);
    assign bus.Scan_Done_Out   = w_scan_done;
    assign bus.Step_Miss_Out   = r_step_miss;
endmodule
`default_nettype wire

// File: doc/neuron_integrator.md
Name: neuron_integrator

Overview:
- Downstream consumer of the TCAM routing memory's fire-mode output.
- Accepts routed synaptic events (destination neuron ID plus signed weight) and integrates them into per-neuron membrane potentials.
- On each timestep pulse, scans all neurons, applying threshold/fire and leak.
- Fired neuron IDs are queued in a small FIFO and presented on a valid/ready output that feeds back into the PacketID_In stream.

Parameters:
- ID_Width, 4, neuron ID width; Neurons = 2**ID_Width.
- Weight_Width, 4, signed two's-complement synaptic weight width.
- Pot_Width, 8, signed membrane potential width.
- Threshold, 8'sd32, fire when pot >= Threshold.
- Leak, 8'd1, per-timestep decay magnitude toward zero.
- FIFO_Depth, 4, spike output FIFO entries (power of two).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- MODE  input  3  shared mode bus; MODE_F=3'b011 enables integration; MODE_RST=3'b101 is a synchronous clear.
- Syn_Valid_In  input  1  synaptic event valid.
- Syn_Ready_Out  output  1  event accepted when Syn_Valid_In and Syn_Ready_Out are both 1.
- DstID_In  input  ID_Width  destination neuron (from Mem DstID_Out).
- Weight_In  input  Weight_Width  signed weight (from Mem Weight_Out).
- Step_In  input  1  timestep-end pulse.
- Spike_Valid_Out  output  1  FIFO not empty.
- Spike_ID_Out  output  ID_Width  FIFO head (first-word-fall-through).
- Spike_Ready_In  input  1  consumer pop.
- Busy_Out  output  1  high while in SCAN.
- Scan_Done_Out  output  1  one-cycle pulse when a scan completes.
- Step_Miss_Out  output  1  sticky; set when Step_In arrives during SCAN.

Behaviour:
- Reset (rst_n=0 at clk edge) or MODE==MODE_RST:
  - all pot[i]=0; FIFO empty; state=IDLE; scan index=0.
  - Syn_Ready_Out, Spike_Valid_Out, Spike_ID_Out, Busy_Out, Scan_Done_Out, Step_Miss_Out all 0.
  - MODE_RST overrides everything, including a scan in progress.
- States: IDLE, SCAN.
- IDLE:
  - Syn_Ready_Out = (MODE==MODE_F).
  - On handshake: pot[DstID_In] <= sat(pot[DstID_In] + sext(Weight_In)), one event per cycle, visible next cycle.
  - Saturation clamps to [-2**(Pot_Width-1), 2**(Pot_Width-1)-1].
- IDLE + Step_In -> SCAN next cycle, index=0. A handshake in the same cycle is applied first, so the scan sees the updated value.
- SCAN processes one neuron per cycle at index i:
  - pot[i] >= Threshold: push i into FIFO; pot[i] <= 0.
  - else pot[i] > 0: pot[i] <= max(pot[i]-Leak, 0).
  - else pot[i] < 0: pot[i] <= min(pot[i]+Leak, 0).
  - else (pot[i] == 0): unchanged.
  - Firing neuron with FIFO full and no pop this cycle: stall; index and pot[i] held, Busy_Out stays 1.
  - FIFO full with a pop in the same cycle: push allowed, no stall.
  - After index Neurons-1 is processed: Scan_Done_Out=1 for that cycle; IDLE next cycle.
- During SCAN:
  - Syn_Ready_Out=0; upstream holds its event.
  - Step_In is ignored and sets Step_Miss_Out (cleared only by reset/MODE_RST).
- FIFO:
  - Spike_Valid_Out = !empty.
  - Pop on Spike_Valid_Out && Spike_Ready_In.
  - Order preserved; pointers wrap modulo FIFO_Depth; count width log2(FIFO_Depth)+1.
  - Pop on empty is a no-op.
- MODE other than MODE_F/MODE_RST while IDLE: no integration, pots hold; Step_In still starts a scan.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0. Then MODE=MODE_F -> Syn_Ready_Out=1.
- Fire: 5 events ID 3, weight +7 (pot=35), then Step_In:
  - Spike_ID_Out=3 with Spike_Valid_Out=1, appearing 5 cycles after the scan starts (after neuron 3 is processed).
  - pot[3]=0 afterward; Scan_Done_Out pulses 16 cycles after the scan starts.
- Saturation/leak: 20 events ID 2, weight -8 -> pot[2]=-128. Step_In -> pot[2]=-127, no spike. Same check for +7 x 20 on ID 5 -> pot=127, fires.
- Backpressure: Spike_Ready_In=0; neurons 0..5 at 35; Step_In:
  - 4 spikes queued; scan stalls at index 4 with Busy_Out=1.
  - Raise Spike_Ready_In -> IDs 0,1,2,3,4,5 delivered in order, then Scan_Done_Out.
- Scan interlock: Syn_Valid_In (ID 7, +3) asserted and Step_In re-pulsed during the scan:
  - Syn_Ready_Out=0 until IDLE; event accepted on the first IDLE cycle; pot[7]=3.
  - Step_Miss_Out=1.
- Mid-scan clear: MODE=MODE_RST at index 8 with FIFO non-empty -> next cycle all pots 0, FIFO empty, IDLE, Busy_Out=0, Step_Miss_Out=0.
